// File: rtl/hidden_layer_mac_if.sv
// Bus between the hidden-layer MAC sequencer and its environment: control
// handshake, input-vector read port, weight-memory address/data and the
// hidden-activation write port.
interface hidden_layer_mac_if;
  logic              start;
  logic              busy;
  logic              done;
  logic [5:0]        in_addr;
  logic signed [7:0] in_data;
  logic [31:0]       weight_sel;
  logic              t;
  logic signed [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic              h_we;
  logic [4:0]        h_addr;
  logic [7:0]        h_data;

  // The MAC sequencer drives the memory addresses and the write port.
  modport master (
    input  start, in_data, w0, w1, w2, w3, w4, w5, w6, w7, w8, w9,
    output busy, done, in_addr, weight_sel, t, h_we, h_addr, h_data
  );

  // The environment supplies input activations and weights and consumes writes.
  modport slave (
    output start, in_data, w0, w1, w2, w3, w4, w5, w6, w7, w8, w9,
    input  busy, done, in_addr, weight_sel, t, h_we, h_addr, h_data
  );
endinterface

// File: rtl/hidden_layer_mac.sv
// Hidden-layer sequencer and MAC: for each of two neuron groups, sweeps the 62
// inputs while accumulating 10 weight*activation products in parallel, then
// drains ReLU/shift/saturate activations one per cycle.
module hidden_layer_mac #(
  parameter int N_IN  = 62,
  parameter int N_PAR = 10,
  parameter int N_GRP = 2,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  hidden_layer_mac_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_e;

  localparam logic [5:0] SEL_LAST = 6'(N_IN - 1);
  localparam logic [3:0] K_LAST   = 4'(N_PAR - 1);

  state_e                   state_q, state_d;
  logic [5:0]               sel_q, sel_d;
  logic [3:0]               k_q, k_d;
  logic                     t_q, t_d;
  logic signed [ACC_W-1:0]  acc_q [N_PAR];
  logic signed [ACC_W-1:0]  acc_d [N_PAR];
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     h_we_q, h_we_d;
  logic [4:0]               h_addr_q, h_addr_d;
  logic [7:0]               h_data_q, h_data_d;

  logic signed [7:0]        w    [N_PAR];
  logic signed [15:0]       prod [N_PAR];

  // ReLU, arithmetic shift and saturation to the 0..127 activation range.
  function automatic logic [7:0] act(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] s;
    s = x >>> SHIFT;
    if (x[ACC_W-1])              act = 8'd0;
    else if (s > ACC_W'(127))    act = 8'd127;
    else                         act = {1'b0, s[6:0]};
  endfunction

  // Gather the weight ports into an array and form the signed 8x8 products.
  always_comb begin
    w[0] = bus.w0; w[1] = bus.w1; w[2] = bus.w2; w[3] = bus.w3; w[4] = bus.w4;
    w[5] = bus.w5; w[6] = bus.w6; w[7] = bus.w7; w[8] = bus.w8; w[9] = bus.w9;
    for (int i = 0; i < N_PAR; i++) prod[i] = w[i] * bus.in_data;
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    sel_d   = sel_q;
    k_d     = k_q;
    t_d     = t_q;
    for (int i = 0; i < N_PAR; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          sel_d   = '0;
          t_d     = 1'b0;
          for (int i = 0; i < N_PAR; i++) acc_d[i] = '0;
        end
      end
      S_ACCUM: begin
        for (int i = 0; i < N_PAR; i++) acc_d[i] = acc_q[i] + ACC_W'(prod[i]);
        sel_d = sel_q + 6'd1;
        if (sel_q == SEL_LAST) begin
          state_d = S_DRAIN;
          sel_d   = '0;
          k_d     = '0;
        end
      end
      S_DRAIN: begin
        k_d = k_q + 4'd1;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (!t_q) begin
            state_d = S_ACCUM;
            t_d     = 1'b1;
            sel_d   = '0;
            for (int i = 0; i < N_PAR; i++) acc_d[i] = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    h_we_d   = (state_d == S_DRAIN);
    h_addr_d = h_addr_q;
    h_data_d = h_data_q;
    if (h_we_d) begin
      h_addr_d = (t_d ? 5'(N_PAR) : 5'd0) + {1'b0, k_d};
      h_data_d = act(acc_d[k_d]);
    end
  end

  // State and output registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      k_q      <= '0;
      t_q      <= 1'b0;
      // NOTE: the accumulators are ordinary flops, not a RAM, so they reset with the rest.
      for (int i = 0; i < N_PAR; i++) acc_q[i] <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      h_we_q   <= 1'b0;
      h_addr_q <= '0;
      h_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      sel_q    <= sel_d;
      k_q      <= k_d;
      t_q      <= t_d;
      for (int i = 0; i < N_PAR; i++) acc_q[i] <= acc_d[i];
      busy_q   <= busy_d;
      done_q   <= done_d;
      h_we_q   <= h_we_d;
      h_addr_q <= h_addr_d;
      h_data_q <= h_data_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.in_addr    = sel_q;
  assign bus.weight_sel = {26'd0, sel_q};
  assign bus.t          = t_q;
  assign bus.h_we       = h_we_q;
  assign bus.h_addr     = h_addr_q;
  assign bus.h_data     = h_data_q;

endmodule
